// File: rtl/psc_pkg.sv
// Shared types and constants for the PSC trigger scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package psc_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_TX = 2'd2,
    HOLD    = 2'd3
  } sched_state_t;

  localparam int PSC_CODE_W = 8;

  // Code sent for channel 0; channel i sends base + i (8-bit wrap)
  localparam logic [PSC_CODE_W-1:0] PSC_CODE_BASE_DEFAULT = 8'h10;

endpackage

// File: rtl/trig_sync_edge.sv
// Two-flop synchronizer plus falling-edge detector for one active-low trigger.
// Latency: input low at edge 0 gives a fall_o pulse after edge 1, one cycle wide.
// Backpressure: none; every detected falling edge pulses once.
// Ports: clk, rst_n (async active-low), trig_n_i (async active-low input),
//        fall_o (one-cycle pulse, clk domain).
module trig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_n_i,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // All flops reset high so an input held low through reset is seen as a fresh edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= trig_n_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/psc_trigger_sched.sv
// Round-robin trigger scheduler sharing one PSC frame transmitter between N_CH EVR inputs.
// Latency: trigger low at edge 0 -> pending after edge 2 -> tx_req after edge 3 (FSM idle, tx not busy).
// Backpressure: requests stay pending while the transmitter is busy, in a frame, or in holdoff.
// Ports: clk, reset (async active-low), evr_trigger/ch_enable (per channel),
//        tx_req/tx_code/tx_ack/tx_busy (transmitter handshake), trigger_out (pulse after ack),
//        grant/pending (status), overrun/overrun_clr (only with PSC_SCHED_OVERRUN_EN).
// Build option: define PSC_SCHED_OVERRUN_EN to add sticky per-channel overrun flags.
module psc_trigger_sched
  import psc_pkg::*;
#(
  parameter int                    N_CH      = 4,
  parameter int                    HOLDOFF   = 100,
  parameter logic [PSC_CODE_W-1:0] CODE_BASE = PSC_CODE_BASE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       evr_trigger,
  input  logic [N_CH-1:0]       ch_enable,
  output logic                  tx_req,
  output logic [PSC_CODE_W-1:0] tx_code,
  input  logic                  tx_ack,
  input  logic                  tx_busy,
  output logic                  trigger_out,
  output logic [N_CH-1:0]       grant,
`ifdef PSC_SCHED_OVERRUN_EN
  output logic [N_CH-1:0]       overrun,
  input  logic                  overrun_clr,
`endif
  output logic [N_CH-1:0]       pending
);

  localparam int IDX_W = $clog2(N_CH);
  // HOLDOFF=0 never loads the counter; keep one bit so the declaration stays legal
  localparam int CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);
  localparam logic [N_CH-1:0]  ONE_HOT0  = {{(N_CH-1){1'b0}}, 1'b1};

  sched_state_t          state_q, state_d;
  logic [N_CH-1:0]       fall;
  logic [N_CH-1:0]       pending_q, pending_d;
  logic [N_CH-1:0]       grant_q;
  logic [N_CH-1:0]       req_vec;
  logic [N_CH-1:0]       ack_clr;
  logic [IDX_W-1:0]      last_q;
  logic [IDX_W-1:0]      win_d;
  logic [IDX_W-1:0]      cand;
  logic                  found;
  logic [PSC_CODE_W-1:0] code_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  trig_q;
  logic                  start;
  logic                  ack_fire;
  logic                  leave;

  // ---------------- input synchronizers ----------------
  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    trig_sync_edge u_sync (
      .clk      (clk),
      .rst_n    (reset),
      .trig_n_i (evr_trigger[i]),
      .fall_o   (fall[i])
    );
  end

  // ---------------- round-robin pick ----------------
  assign req_vec = pending_q & ch_enable;

  // First requester found scanning upward from last_q+1, wrapping at N_CH
  always_comb begin
    win_d = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = IDX_W'((int'(last_q) + k) % N_CH);
      if (!found && req_vec[cand]) begin
        win_d = cand;
        found = 1'b1;
      end
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found && !tx_busy) state_d = REQ;
      REQ:     if (tx_ack) state_d = WAIT_TX;
      WAIT_TX: if (!tx_busy) state_d = (HOLDOFF == 0) ? IDLE : HOLD;
      HOLD:    if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    tx_req   = (state_q == REQ);
    start    = (state_q == IDLE) && (state_d == REQ);
    ack_fire = (state_q == REQ) && tx_ack;
    leave    = (state_q != IDLE) && (state_d == IDLE);
  end

  // grant_q is one-hot on the winner, so it doubles as the ack clear mask
  assign ack_clr = ack_fire ? grant_q : '0;

  // New edges OR in after the ack clear so a winner re-edge on the ack cycle survives.
  // Disabled channels drop their request unless they already own the transmitter.
  assign pending_d = ((pending_q & ~ack_clr) | (fall & ch_enable)) & (ch_enable | grant_q);

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      grant_q   <= '0;
      last_q    <= IDX_W'(N_CH - 1);
      code_q    <= '0;
      cnt_q     <= '0;
      trig_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      trig_q    <= ack_fire;

      if (start) begin
        last_q  <= win_d;
        code_q  <= CODE_BASE + PSC_CODE_W'(win_d);
        grant_q <= ONE_HOT0 << win_d;
      end else if (leave) begin
        grant_q <= '0;
      end

      if ((state_q == WAIT_TX) && !tx_busy) begin
        cnt_q <= HOLD_LOAD;
      end else if ((state_q == HOLD) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign tx_code     = code_q;
  assign grant       = grant_q;
  assign pending     = pending_q;
  assign trigger_out = trig_q;

  // ---------------- overrun flags ----------------
`ifdef PSC_SCHED_OVERRUN_EN
  logic [N_CH-1:0] overrun_q;
  logic [N_CH-1:0] ovr_set;

  // A re-edge on the winner in its ack cycle becomes a new request, not an overrun
  assign ovr_set = fall & ch_enable & pending_q & ~ack_clr;

  // Set is OR-ed after the clear so a same-cycle set wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overrun_q <= '0;
    else        overrun_q <= (overrun_clr ? '0 : overrun_q) | ovr_set;
  end

  assign overrun = overrun_q;
`else
  // Without overrun tracking, edges on an already-pending channel are dropped silently.
`endif

endmodule

// File: tb/tb_psc_trigger_sched.sv
module tb_psc_trigger_sched;
  import psc_pkg::*;

  localparam int N_CH    = 4;
  localparam int HOLDOFF = 100;

  logic                  clk;
  logic                  reset;
  logic [N_CH-1:0]       evr_trigger;
  logic [N_CH-1:0]       ch_enable;
  logic                  tx_req;
  logic [PSC_CODE_W-1:0] tx_code;
  logic                  tx_ack;
  logic                  tx_busy;
  logic                  trigger_out;
  logic [N_CH-1:0]       grant;
  logic [N_CH-1:0]       pending;
`ifdef PSC_SCHED_OVERRUN_EN
  logic [N_CH-1:0]       overrun;
  logic                  overrun_clr;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_trig   = 0;

  psc_trigger_sched #(.N_CH(N_CH), .HOLDOFF(HOLDOFF), .CODE_BASE(8'h10)) dut (
    .clk         (clk),
    .reset       (reset),
    .evr_trigger (evr_trigger),
    .ch_enable   (ch_enable),
    .tx_req      (tx_req),
    .tx_code     (tx_code),
    .tx_ack      (tx_ack),
    .tx_busy     (tx_busy),
    .trigger_out (trigger_out),
    .grant       (grant),
`ifdef PSC_SCHED_OVERRUN_EN
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
`endif
    .pending     (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (trigger_out) n_trig++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Wait for tx_req, check the grant, ack after 2 cycles, raise busy, check the pulse
  task automatic begin_frame(input int ch, output int waited);
    waited = 0;
    while (!tx_req && waited < 2000) begin
      step();
      waited++;
    end
    chk("req_seen", {31'd0, tx_req}, 32'd1);
    chk("tx_code", {24'd0, tx_code}, 32'h10 + ch);
    chk("grant", {28'd0, grant}, 32'd1 << ch);
    chk("pend_win", {31'd0, pending[ch]}, 32'd1);
    steps(2);
    tx_ack  = 1'b1;
    tx_busy = 1'b1;
    step();
    tx_ack = 1'b0;
    chk("req_drop", {31'd0, tx_req}, 32'd0);
    chk("trig_hi", {31'd0, trigger_out}, 32'd1);
    step();
    chk("trig_1cyc", {31'd0, trigger_out}, 32'd0);
  endtask

  task automatic end_frame(input int busy_len);
    steps(busy_len);
    tx_busy = 1'b0;
  endtask

  int w;
  int t0;
  int gap;

  initial begin
    reset       = 1'b0;
    evr_trigger = '1;
    ch_enable   = '1;
    tx_ack      = 1'b0;
    tx_busy     = 1'b0;
`ifdef PSC_SCHED_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    steps(3);
    chk("rst_req", {31'd0, tx_req}, 32'd0);
    chk("rst_code", {24'd0, tx_code}, 32'd0);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_pend", {28'd0, pending}, 32'd0);
    chk("rst_trig", {31'd0, trigger_out}, 32'd0);
`ifdef PSC_SCHED_OVERRUN_EN
    chk("rst_ovr", {28'd0, overrun}, 32'd0);
`endif
    reset = 1'b1;
    steps(2);

    // ---- single trigger on ch1 with holdoff timing ----
    t0 = n_trig;
    evr_trigger[1] = 1'b0;
    steps(3);
    chk("t1_pend", {28'd0, pending}, 32'b0010);
    chk("t1_req_early", {31'd0, tx_req}, 32'd0);
    begin_frame(1, w);
    chk("t1_req_lat", w, 1);
    end_frame(50);
    gap = 0;
    while (grant != '0 && gap < 500) begin
      step();
      gap++;
    end
    chk("t1_holdoff", gap, HOLDOFF + 1);
    steps(400);
    chk("t1_no_second", {31'd0, tx_req}, 32'd0);
    chk("t1_trig_cnt", n_trig - t0, 1);
    evr_trigger[1] = 1'b1;
    steps(5);

    // ---- round robin: all four fall together after reset ----
    reset = 1'b0;
    steps(2);
    reset = 1'b1;
    steps(2);
    t0 = n_trig;
    evr_trigger = '0;
    begin_frame(0, w);
    chk("rr_lat0", w, 4);
    for (int c = 1; c < N_CH; c++) begin
      end_frame(5);
      begin_frame(c, w);
      chk("rr_gap", w, HOLDOFF + 2);
    end
    end_frame(5);
    chk("rr_trig_cnt", n_trig - t0, 4);
    evr_trigger = '1;
    steps(120);

    // ---- fairness: ch0 retriggers while ch2 waits ----
    evr_trigger[0] = 1'b0;
    evr_trigger[2] = 1'b0;
    begin_frame(0, w);
    evr_trigger[0] = 1'b1;
    steps(2);
    evr_trigger[0] = 1'b0;
    steps(4);
    chk("fair_pend", {28'd0, pending}, 32'b0101);
    end_frame(5);
    begin_frame(2, w);
    end_frame(5);
    begin_frame(0, w);
    end_frame(5);
    evr_trigger = '1;
    steps(120);

    // ---- disable a pending channel ----
    t0 = n_trig;
    tx_busy = 1'b1;
    evr_trigger[2] = 1'b0;
    steps(4);
    chk("dis_pend", {28'd0, pending}, 32'b0100);
    ch_enable[2] = 1'b0;
    step();
    chk("dis_clr", {28'd0, pending}, 32'd0);
    tx_busy = 1'b0;
    steps(10);
    chk("dis_noreq", {31'd0, tx_req}, 32'd0);
    evr_trigger[2] = 1'b1;
    steps(3);
    evr_trigger[2] = 1'b0;
    steps(4);
    chk("dis_ignore", {28'd0, pending}, 32'd0);
    ch_enable[2] = 1'b1;
    steps(3);
    chk("dis_reen", {28'd0, pending}, 32'd0);
    chk("dis_trig", n_trig - t0, 0);
    evr_trigger[2] = 1'b1;
    steps(5);

    // ---- duplicate ch3 edges while ch0 is on air ----
    t0 = n_trig;
    evr_trigger[0] = 1'b0;
    begin_frame(0, w);
    evr_trigger[3] = 1'b0;
    steps(4);
    chk("dup_pend1", {28'd0, pending}, 32'b1000);
    evr_trigger[3] = 1'b1;
    steps(3);
    evr_trigger[3] = 1'b0;
    steps(4);
    chk("dup_pend2", {28'd0, pending}, 32'b1000);
`ifdef PSC_SCHED_OVERRUN_EN
    chk("ovr_set", {28'd0, overrun}, 32'b1000);
`endif
    end_frame(5);
    begin_frame(3, w);
    end_frame(5);
    steps(150);
    chk("dup_noreq", {31'd0, tx_req}, 32'd0);
    chk("dup_trig", n_trig - t0, 2);
`ifdef PSC_SCHED_OVERRUN_EN
    chk("ovr_sticky", {28'd0, overrun}, 32'b1000);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("ovr_clr", {28'd0, overrun}, 32'd0);
`endif
    evr_trigger = '1;
    steps(5);

    // ---- reset during REQ ----
    evr_trigger[2] = 1'b0;
    w = 0;
    while (!tx_req && w < 2000) begin
      step();
      w++;
    end
    chk("mid_req", {31'd0, tx_req}, 32'd1);
    chk("mid_grant", {28'd0, grant}, 32'b0100);
    reset = 1'b0;
    #2;
    chk("mid_rst_req", {31'd0, tx_req}, 32'd0);
    chk("mid_rst_grant", {28'd0, grant}, 32'd0);
    chk("mid_rst_pend", {28'd0, pending}, 32'd0);
    chk("mid_rst_code", {24'd0, tx_code}, 32'd0);
    evr_trigger = '0;
    steps(3);
    reset = 1'b1;
    begin_frame(0, w);
    end_frame(5);
    evr_trigger = '1;
    steps(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
